// File: rtl/decode_issue_unit.sv
// decode_issue_unit: decodes fetched instructions, reads the register file with write-back bypass,
// tracks pending destinations for RAW/WAW stalls and registers the ALU issue stage.
module decode_issue_unit #(
  parameter int DATA_W  = 16,
  parameter int NREG    = 16,
  parameter int INSTR_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  input  logic               wb_en,
  input  logic [3:0]         wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [5:0]         op_dec,
  output logic [DATA_W-1:0]  A,
  output logic [DATA_W-1:0]  B,
  output logic [DATA_W-1:0]  data_in,
  output logic               issue_valid,
  output logic [3:0]         issue_rd,
  output logic [15:0]        stall_cnt
);
  logic [DATA_W-1:0] rf_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d, clr, set, live;
  logic [5:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, din_q, din_d, src_s, src_t, imm_x;
  logic [3:0]        rd_q, rd_d, rd, rs, rt;
  logic [4:0]        op;
  logic              iv_q, imm_sel, wb_we, rt_use, hazard, acc;
  logic [15:0]       stall_q, stall_d;
  assign imm_sel = instr[23];
  assign op      = instr[22:18];
  assign rd      = instr[17:14];
  assign rs      = instr[13:10];
  assign rt      = instr[9:6];
  assign imm_x   = {{(DATA_W-6){instr[5]}}, instr[5:0]};
  assign wb_we   = wb_en && wb_addr != 4'd0;
  always_comb begin
    clr    = wb_we ? (NREG'(1) << wb_addr) : '0;
    live   = pend_q & ~clr;
    // rt still feeds store data in immediate form unless the op is a NOP
    rt_use = !imm_sel || op != 5'd0;
    hazard = live[rs] || (rt_use && live[rt]) || live[rd];
    in_ready = !hazard && !flush;
    acc    = in_valid && in_ready;
    src_s  = rs == 4'd0 ? '0 : (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
    src_t  = rt == 4'd0 ? '0 : (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];
    set    = (acc && op != 5'd0 && rd != 4'd0) ? (NREG'(1) << rd) : '0;
    pend_d = (pend_q & ~clr) | set;
    op_d   = acc ? {1'b0, op} : 6'd0;
    a_d    = acc ? src_s : a_q;
    b_d    = acc ? (imm_sel ? imm_x : src_t) : b_q;
    din_d  = acc ? src_t : din_q;
    rd_d   = acc ? rd : rd_q;
    stall_d = (in_valid && hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rf_q    <= '{default: '0};
      pend_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      din_q   <= '0;
      rd_q    <= '0;
      iv_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      if (wb_we) rf_q[wb_addr] <= wb_data;
      pend_q  <= pend_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      iv_q    <= acc;
      stall_q <= stall_d;
    end
  assign op_dec      = op_q;
  assign A           = a_q;
  assign B           = b_q;
  assign data_in     = din_q;
  assign issue_rd    = rd_q;
  assign issue_valid = iv_q;
  assign stall_cnt   = stall_q;
endmodule

// File: tb/tb_decode_issue_unit.sv
// tb_decode_issue_unit: directed and random checks of decode_issue_unit against a behavioural model.
module tb_decode_issue_unit;
  logic        clk = 0, reset = 0, in_valid = 0, flush = 0, wb_en = 0;
  logic        in_ready, issue_valid;
  logic [23:0] instr = '0;
  logic [3:0]  wb_addr = '0, issue_rd;
  logic [15:0] wb_data = '0, A, B, data_in, stall_cnt;
  logic [5:0]  op_dec;
  int errors = 0, checks = 0;

  decode_issue_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .op_dec(op_dec),
    .A(A), .B(B), .data_in(data_in), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] m_rf [16];
  bit          m_pend [16];
  logic [5:0]  m_op;
  logic [15:0] m_a, m_b, m_din, m_stall;
  logic [3:0]  m_rd;
  logic        m_iv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mk(input bit imm, input int op, input int rd, input int rs,
                                     input int rt, input int imm6);
    logic [23:0] w;
    w = {imm, 5'(op), 4'(rd), 4'(rs), 4'(rt), 6'(imm6)};
    return w;
  endfunction

  function automatic logic [15:0] rd_src(input int x);
    if (x == 0) return 16'h0;
    if (wb_en && wb_addr == 4'(x)) return wb_data;
    return m_rf[x];
  endfunction

  function automatic bit busy(input int x);
    return x != 0 && m_pend[x] && !(wb_en && wb_addr == 4'(x));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin m_rf[i] = 0; m_pend[i] = 0; end
    m_op = 0; m_a = 0; m_b = 0; m_din = 0; m_rd = 0; m_iv = 0; m_stall = 0;
  endtask

  task automatic chk_outs();
    chk("op_dec", 32'(op_dec), 32'(m_op));
    chk("A", 32'(A), 32'(m_a));
    chk("B", 32'(B), 32'(m_b));
    chk("data_in", 32'(data_in), 32'(m_din));
    chk("issue_valid", 32'(issue_valid), 32'(m_iv));
    chk("issue_rd", 32'(issue_rd), 32'(m_rd));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  task automatic step();
    int op, rd, rs, rt;
    bit imm, haz, acc;
    logic [15:0] sa, st;
    imm = instr[23]; op = int'(instr[22:18]); rd = int'(instr[17:14]);
    rs = int'(instr[13:10]); rt = int'(instr[9:6]);
    haz = busy(rs) || ((!imm || op != 0) && busy(rt)) || busy(rd);
    acc = in_valid && !haz && !flush;
    sa = rd_src(rs); st = rd_src(rt);
    #1 chk("in_ready", 32'(in_ready), 32'(!haz && !flush));
    @(posedge clk);
    if (in_valid && haz && m_stall != 16'hFFFF) m_stall++;
    if (wb_en && wb_addr != 0) begin m_rf[wb_addr] = wb_data; m_pend[wb_addr] = 0; end
    if (acc) begin
      m_op = 6'(op); m_a = sa; m_din = st; m_rd = 4'(rd); m_iv = 1;
      m_b = imm ? {{10{instr[5]}}, instr[5:0]} : st;
      if (op != 0 && rd != 0) m_pend[rd] = 1;
    end else begin
      m_op = 0; m_iv = 0;
    end
    #1 chk_outs();
    in_valid = 0; flush = 0; wb_en = 0;
  endtask

  initial begin
    m_reset();
    #12 chk_outs();
    chk("in_ready_rst", 32'(in_ready), 32'd1);
    reset = 1;
    @(posedge clk); #1;
    wb_en = 1; wb_addr = 1; wb_data = 16'h4000; step();
    wb_en = 1; wb_addr = 2; wb_data = 16'hC000; step();
    in_valid = 1; instr = mk(0, 5'b01010, 3, 1, 2, 0); step();
    chk("t1_op", 32'(op_dec), 32'h0A);
    chk("t1_A", 32'(A), 32'h4000);
    chk("t1_B", 32'(B), 32'hC000);
    chk("t1_din", 32'(data_in), 32'hC000);
    chk("t1_iv", 32'(issue_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; instr = mk(0, 1, 4, 3, 0, 0); step();
      chk("t2_stall", 32'(stall_cnt), 32'(i + 1));
    end
    in_valid = 1; instr = mk(0, 1, 4, 3, 0, 0);
    wb_en = 1; wb_addr = 3; wb_data = 16'h0008; step();
    chk("t2_bypassA", 32'(A), 32'h0008);
    chk("t2_iv", 32'(issue_valid), 32'd1);
    in_valid = 1; instr = mk(1, 1, 5, 0, 0, 6'b111110); step();
    chk("t3_A", 32'(A), 32'h0000);
    chk("t3_B", 32'(B), 32'hFFFE);
    in_valid = 1; flush = 1; instr = mk(0, 2, 6, 1, 2, 0); step();
    chk("t4_op", 32'(op_dec), 32'd0);
    chk("t4_iv", 32'(issue_valid), 32'd0);
    in_valid = 1; instr = mk(0, 2, 6, 1, 2, 0); step();
    chk("t4_accept", 32'(issue_valid), 32'd1);
    wb_en = 1; wb_addr = 0; wb_data = 16'h1234; step();
    in_valid = 1; instr = mk(0, 3, 0, 0, 0, 0); step();
    chk("t5_A", 32'(A), 32'h0);
    chk("t5_rd0", 32'(issue_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin in_valid = 1; instr = mk(0, 1, 7, 5, 0, 0); step(); end
    chk("t6_stall7", 32'(stall_cnt), 32'd7);
    instr = mk(0, 1, 7, 5, 0, 0);
    reset = 0; m_reset();
    #1 chk_outs();
    chk("t6_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 chk_outs();
    reset = 1;
    @(posedge clk); #1;
    wb_en = 1; wb_addr = 7; wb_data = 16'h0055; step();
    in_valid = 1; instr = mk(0, 1, 8, 7, 0, 0); step();
    chk("t7_A", 32'(A), 32'h0055);
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      instr = 24'($urandom);
      if ($urandom_range(0, 3) == 0) instr[13:6] = 8'h00;
      wb_en = 1'($urandom_range(0, 1));
      wb_addr = 4'($urandom);
      wb_data = 16'($urandom);
      flush = !in_valid && $urandom_range(0, 3) == 0;
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
